// File: rtl/reg_bank.sv
// 16x32 register file: two combinational read ports, one synchronous write port, r15 tapped for VGA.
// Latency: reads 0 cycles; writes become visible after the capturing edge. No backpressure.
module reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int VGA_REG    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] wa3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] r_vga
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] VGA_IDX = ADDR_WIDTH'(VGA_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Reset wins over a same-cycle write; r0 is an ordinary register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we3) begin
      regs[wa3] <= wd3;
    end
  end

  // No write-through bypass: reads always see the pre-edge state.
  assign rd1   = regs[ra1];
  assign rd2   = regs[ra2];
  assign r_vga = regs[VGA_IDX];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: a reference array predicts rd1/rd2/r_vga before and after each edge.
module tb_reg_bank;

  logic        clk;
  logic        rst;
  logic        we3;
  logic [3:0]  ra1, ra2, wa3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, r_vga;

  reg_bank dut (
    .clk   (clk),
    .rst   (rst),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .r_vga (r_vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] vga;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [16];
  int          vectors;
  int          miscompares;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict from the model for the current read addresses.
  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.rd1 = model[ra1];
    e.rd2 = model[ra2];
    e.vga = model[15];
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, "_rd1"}, rd1, e.rd1);
      check_val({e.tag, "_rd2"}, rd2, e.rd2);
      check_val({e.tag, "_vga"}, r_vga, e.vga);
    end
  endtask

  // Combinational read only, no clock edge.
  task automatic peek(input string tag, input logic [3:0] a1, input logic [3:0] a2);
    ra1 = a1;
    ra2 = a2;
    push_exp(tag);
    #1;
    pop_check();
  endtask

  // Drive one cycle from just after a negedge: check old state, take the edge, check new state.
  task automatic cycle(input string tag, input logic r, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    rst = r;
    we3 = we;
    wa3 = wa;
    wd3 = wd;
    ra1 = a1;
    ra2 = a2;
    push_exp({tag, "_pre"});
    #1;
    pop_check();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
    end else if (we) begin
      model[wa] = wd;
    end
    push_exp({tag, "_post"});
    #1;
    pop_check();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    rst = 1'b1;
    we3 = 1'b0;
    ra1 = 4'd0;
    ra2 = 4'd0;
    wa3 = 4'd0;
    wd3 = 32'h0;

    // Power-up contents are undefined, so take reset edges before checking.
    @(posedge clk);
    @(posedge clk);
    cycle("rst_hold", 1'b1, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1);
    cycle("rst_rel", 1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0);
    peek("rst_r1", 4'd1, 4'd1);

    cycle("wr_r0", 1'b0, 1'b1, 4'd0, 32'hFF, 4'd0, 4'd1);
    cycle("rd_r0", 1'b0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd1);
    cycle("we_gate", 1'b0, 1'b0, 4'hF, 32'hFF, 4'd0, 4'hF);
    cycle("wr_r15", 1'b0, 1'b1, 4'hF, 32'hFF, 4'd0, 4'hF);
    cycle("rdw_r5", 1'b0, 1'b1, 4'd5, 32'hA5A5A5A5, 4'd5, 4'd5);
    cycle("rdw_r5b", 1'b0, 1'b1, 4'd5, 32'h5A5A5A5A, 4'd5, 4'd0);
    cycle("wr_r3", 1'b0, 1'b1, 4'd3, 32'hCAFE0003, 4'd3, 4'd15);
    cycle("rst_prio", 1'b1, 1'b1, 4'd3, 32'h1234, 4'd3, 4'd15);
    for (int i = 0; i < 16; i += 2) begin
      peek("rst_all", 4'(i), 4'(i + 1));
    end

    // Random traffic with occasional resets and disabled writes.
    for (int n = 0; n < 300; n++) begin
      cycle("rand",
            ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            $urandom(),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 16; i++) begin
      peek("final", 4'(i), 4'(15 - i));
    end

    if (sb_q.size() != 0) begin
      check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
